// File: rtl/lru_matrix_tracker.sv
// Matrix-LRU replacement tracker for one cache set, with a registered victim way.
// Optional LRU_WAY_LOCK_EN adds lock_mask; locked ways are never offered as the victim.
module lru_matrix_tracker #(
    parameter  int WAYS  = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             access_valid,
    input  logic [WAY_W-1:0] access_way,
    input  logic             access_fill,
    input  logic             inval_valid,
    input  logic [WAY_W-1:0] inval_way,
`ifdef LRU_WAY_LOCK_EN
    input  logic [WAYS-1:0]  lock_mask,
`endif
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_valid,
    output logic             all_valid
);

    // Handshake: no back-pressure. access_valid and inval_valid are each taken
    // in the cycle they are high; effects show on victim_way/all_valid after that edge.

    logic [WAYS-1:0] mat_q [WAYS];
    logic [WAYS-1:0] mat_d [WAYS];
    logic [WAYS-1:0] valid_q;
    logic [WAYS-1:0] valid_d;
    logic [WAYS-1:0] locked;
    logic            acc_en;
    logic            inv_en;
    logic            all_locked;
    logic [WAY_W-1:0] victim_d;

`ifdef LRU_WAY_LOCK_EN
    assign locked = lock_mask;
`else
    assign locked = '0;
`endif

    assign all_locked = &locked;
    assign acc_en = access_valid && (int'(access_way) < WAYS);
    // A same-way invalidate is dropped so the access alone decides the result.
    assign inv_en = inval_valid && (int'(inval_way) < WAYS)
                    && !(acc_en && (access_way == inval_way));

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < WAYS; i++) begin
            mat_d[i] = mat_q[i];
        end
        if (inv_en) begin
            for (int i = 0; i < WAYS; i++) begin
                if (i == int'(inval_way)) begin
                    valid_d[i] = 1'b0;
                end
                for (int j = 0; j < WAYS; j++) begin
                    if (i == int'(inval_way)) mat_d[i][j] = 1'b0;
                    if (j == int'(inval_way)) mat_d[i][j] = 1'b1;
                end
            end
        end
        if (acc_en) begin
            for (int i = 0; i < WAYS; i++) begin
                if (i == int'(access_way) && access_fill) begin
                    valid_d[i] = 1'b1;
                end
                for (int j = 0; j < WAYS; j++) begin
                    if (i == int'(access_way)) mat_d[i][j] = 1'b1;
                    if (j == int'(access_way)) mat_d[i][j] = 1'b0;
                end
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            mat_d[i][i] = 1'b0;
        end
    end

    // Victim: lowest eligible invalid way first, otherwise the oldest eligible way.
    always_comb begin
        logic found;
`ifdef LRU_WAY_LOCK_EN
        int best_cnt;
        best_cnt = WAYS + 1;
`endif
        victim_d = '0;
        found    = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found && !valid_d[i] && !locked[i]) begin
                victim_d = WAY_W'(i);
                found    = 1'b1;
            end
        end
`ifdef LRU_WAY_LOCK_EN
        for (int i = 0; i < WAYS; i++) begin
            if (!found && !locked[i] && ($countones(mat_d[i]) < best_cnt)) begin
                victim_d = WAY_W'(i);
                best_cnt = $countones(mat_d[i]);
            end
        end
`else
        for (int i = 0; i < WAYS; i++) begin
            if (!found && (mat_d[i] == '0)) begin
                victim_d = WAY_W'(i);
                found    = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WAYS; i++) begin
                for (int j = 0; j < WAYS; j++) begin
                    mat_q[i][j] <= (j < i);
                end
            end
            valid_q      <= '0;
            victim_way   <= '0;
            victim_valid <= 1'b0;
            all_valid    <= 1'b0;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                mat_q[i] <= mat_d[i];
            end
            valid_q      <= valid_d;
            all_valid    <= &valid_d;
            victim_valid <= !all_locked;
            if (!all_locked) begin
                victim_way <= victim_d;
            end
        end
    end

endmodule

// File: tb/tb_lru_matrix_tracker.sv
// Randomised bench for lru_matrix_tracker against a recency-list reference model.
// Build with LRU_WAY_LOCK_EN defined to also exercise lock_mask.
module tb_lru_matrix_tracker;

    localparam int WAYS  = 4;
    localparam int WAY_W = $clog2(WAYS);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             access_valid = 1'b0;
    logic [WAY_W-1:0] access_way = '0;
    logic             access_fill = 1'b0;
    logic             inval_valid = 1'b0;
    logic [WAY_W-1:0] inval_way = '0;
    logic [WAYS-1:0]  lock_mask = '0;
    logic [WAY_W-1:0] victim_way;
    logic             victim_valid;
    logic             all_valid;

    int checks = 0;
    int passes = 0;

    // Reference model: recency list, front = least recently used.
    int rec_q[$];
    bit m_valid[WAYS];
    int m_victim;
    bit m_vv;

    lru_matrix_tracker #(.WAYS(WAYS)) dut (
        .clk          (clk),
        .reset        (reset),
        .access_valid (access_valid),
        .access_way   (access_way),
        .access_fill  (access_fill),
        .inval_valid  (inval_valid),
        .inval_way    (inval_way),
`ifdef LRU_WAY_LOCK_EN
        .lock_mask    (lock_mask),
`endif
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .all_valid    (all_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        rec_q = {};
        for (int i = 0; i < WAYS; i++) begin
            rec_q.push_back(i);
            m_valid[i] = 1'b0;
        end
        m_victim = 0;
        m_vv     = 1'b0;
    endfunction

    function automatic void remove_way(input int k);
        for (int i = 0; i < rec_q.size(); i++) begin
            if (rec_q[i] == k) begin
                rec_q.delete(i);
                break;
            end
        end
    endfunction

    function automatic void model_step(input bit av, input int aw, input bit af,
                                       input bit iv, input int iw, input logic [WAYS-1:0] lk);
        int pick;
        if (iv && !(av && aw == iw)) begin
            remove_way(iw);
            rec_q.push_front(iw);
            m_valid[iw] = 1'b0;
        end
        if (av) begin
            remove_way(aw);
            rec_q.push_back(aw);
            if (af) m_valid[aw] = 1'b1;
        end
        if (lk == {WAYS{1'b1}}) begin
            m_vv = 1'b0;
        end else begin
            m_vv = 1'b1;
            pick = -1;
            for (int i = 0; i < WAYS; i++) begin
                if (pick < 0 && !m_valid[i] && !lk[i]) pick = i;
            end
            for (int i = 0; i < rec_q.size(); i++) begin
                if (pick < 0 && !lk[rec_q[i]]) pick = rec_q[i];
            end
            m_victim = pick;
        end
    endfunction

    function automatic bit model_all_valid();
        bit r = 1'b1;
        for (int i = 0; i < WAYS; i++) r &= m_valid[i];
        return r;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".victim_way"}, 32'(victim_way), 32'(m_victim));
        check({tag, ".all_valid"}, 32'(all_valid), 32'(model_all_valid()));
        check({tag, ".victim_valid"}, 32'(victim_valid), 32'(m_vv));
    endtask

    // Called at a negedge: drive, let one rising edge pass, check at the next negedge.
    task automatic drive_cycle(input string tag, input bit av, input int aw, input bit af,
                               input bit iv, input int iw);
        access_valid = av;
        access_way   = WAY_W'(aw);
        access_fill  = af;
        inval_valid  = iv;
        inval_way    = WAY_W'(iw);
        @(posedge clk);
        model_step(av, aw, af, iv, iw, lock_mask);
        @(negedge clk);
        access_valid = 1'b0;
        inval_valid  = 1'b0;
        check_model(tag);
    endtask

    task automatic fill_all_and_check(input string tag);
        int exp_seq[4] = '{1, 2, 3, 0};
        for (int w = 0; w < 4; w++) begin
            drive_cycle(tag, 1'b1, w, 1'b1, 1'b0, 0);
            check({tag, ".seq"}, 32'(victim_way), 32'(exp_seq[w]));
        end
        check({tag, ".all_valid_after_fill3"}, 32'(all_valid), 32'd1);
    endtask

    initial begin
        model_reset();
        #2;
        check("reset.victim_way", 32'(victim_way), 32'd0);
        check("reset.all_valid", 32'(all_valid), 32'd0);
        check("reset.victim_valid", 32'(victim_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_cycle("idle", 1'b0, 0, 1'b0, 1'b0, 0);
        check("idle.victim_valid_up", 32'(victim_valid), 32'd1);

        fill_all_and_check("fill");

        drive_cycle("hit0", 1'b1, 0, 1'b0, 1'b0, 0);
        drive_cycle("hit2", 1'b1, 2, 1'b0, 1'b0, 0);
        drive_cycle("hit1", 1'b1, 1, 1'b0, 1'b0, 0);
        check("hits.lru3", 32'(victim_way), 32'd3);
        drive_cycle("hit3", 1'b1, 3, 1'b0, 1'b0, 0);
        check("hits.lru0", 32'(victim_way), 32'd0);

        drive_cycle("inv2_acc0", 1'b1, 0, 1'b0, 1'b1, 2);
        check("inv2_acc0.victim", 32'(victim_way), 32'd2);
        check("inv2_acc0.all_valid", 32'(all_valid), 32'd0);
        drive_cycle("same_way1", 1'b1, 1, 1'b0, 1'b1, 1);
        check("same_way1.victim", 32'(victim_way), 32'd2);
        drive_cycle("refill2", 1'b1, 2, 1'b1, 1'b0, 0);
        check("refill2.all_valid", 32'(all_valid), 32'd1);
        check("refill2.lru3", 32'(victim_way), 32'd3);
        drive_cycle("hit3b", 1'b1, 3, 1'b0, 1'b0, 0);
        drive_cycle("hit0b", 1'b1, 0, 1'b0, 1'b0, 0);
        check("way1_after_0.lru1", 32'(victim_way), 32'd1);

        // Asynchronous reset in the middle of a cycle.
        drive_cycle("pre_reset", 1'b1, 1, 1'b0, 1'b1, 3);
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset.victim_way", 32'(victim_way), 32'd0);
        check("mid_reset.all_valid", 32'(all_valid), 32'd0);
        check("mid_reset.victim_valid", 32'(victim_valid), 32'd0);
        @(negedge clk);
        check("mid_reset.held_victim_valid", 32'(victim_valid), 32'd0);
        reset = 1'b0;
        model_reset();
        fill_all_and_check("refill");

`ifdef LRU_WAY_LOCK_EN
        lock_mask = 4'b0001;
        drive_cycle("lock0", 1'b0, 0, 1'b0, 1'b0, 0);
        check("lock0.victim", 32'(victim_way), 32'd1);
        lock_mask = 4'b1111;
        drive_cycle("lockall", 1'b0, 0, 1'b0, 1'b0, 0);
        check("lockall.victim_valid", 32'(victim_valid), 32'd0);
        check("lockall.victim_hold", 32'(victim_way), 32'd1);
        lock_mask = 4'b0000;
`endif

        for (int n = 0; n < 400; n++) begin
`ifdef LRU_WAY_LOCK_EN
            lock_mask = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '0;
`endif
            drive_cycle("rand",
                        1'($urandom_range(0, 1)), int'($urandom_range(0, WAYS - 1)),
                        1'($urandom_range(0, 1)),
                        ($urandom_range(0, 2) == 0), int'($urandom_range(0, WAYS - 1)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lru_matrix_tracker.md
Name: lru_matrix_tracker

Overview:
- Parametrised N-way matrix-LRU replacement tracker for one cache set.
- Holds the WAYS x WAYS age matrix and the per-way valid bits internally, and updates them on hit/fill/invalidate events.
- Presents a registered victim way to the cache controller: the lowest invalid way first, otherwise the least-recently-used way.
- Replaces the external square matrix plus combinational priority encoder pair.

Parameters:
- WAYS, 4, number of ways; legal range 2..16.
- WAY_W, $clog2(WAYS), way index width; localparam, not overridable.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high reset.
- access_valid, input, 1, hit or fill touches access_way this cycle.
- access_way, input, WAY_W, way being touched.
- access_fill, input, 1, qualifies access_valid as a fill; sets that way's valid bit.
- inval_valid, input, 1, invalidate inval_way this cycle.
- inval_way, input, WAY_W, way being invalidated.
- victim_way, output, WAY_W, registered replacement candidate.
- victim_valid, output, 1, victim_way reflects current state.
- all_valid, output, 1, registered; every way valid.

Behaviour:
- Matrix M[i][j], i != j; diagonal is constant 0. Row i all-zero means way i is LRU.
- On reset, M[i][j] = 1 for j < i, else 0:
  - way 0 is LRU, way WAYS-1 is MRU.
  - All valid bits = 0.
  - victim_way = 0, victim_valid = 0, all_valid = 0.
- Access of way k, on access_valid:
  - Row k set to all 1 except the diagonal.
  - Column k cleared.
  - Way k becomes MRU.
  - If access_fill = 1, valid[k] <= 1. A hit (access_fill = 0) does not change valid bits.
- Invalidate of way k, on inval_valid:
  - valid[k] <= 0.
  - Row k cleared; column k set to 1 except the diagonal.
  - Way k becomes LRU.
- Simultaneous access and invalidate, different ways:
  - Apply invalidate first, then access, in the same cycle.
  - Both updates are visible next cycle.
- Simultaneous access and invalidate, same way: access wins.
  - Matrix and valid bit update as the access only.
  - A hit leaves the valid bit unchanged.
- Out-of-range way index (non-power-of-2 WAYS): that event is ignored entirely.
- Victim selection, combinational from next-state matrix/valid, registered into victim_way:
  - If any valid bit is 0, victim = lowest-index invalid way.
  - Else victim = lowest-index way whose row is all zero. Exactly one such way exists by construction; the lowest-index rule only resolves corruption.
- Latency: an event in cycle t is reflected in victim_way/all_valid at the clock edge ending cycle t. Outputs are usable in cycle t+1.
- victim_valid:
  - Goes 1 on the first rising clk after reset deasserts.
  - Stays 1 until the next reset.
- Reset asserted mid-operation: immediate asynchronous return to reset values; any in-flight event is discarded.
- No back-pressure: one access and one invalidate may be accepted every cycle.

Optional Feature:
- Macro LRU_WAY_LOCK_EN.
- Defined:
  - Adds input lock_mask [WAYS-1:0]. Locked ways are excluded from both victim rules; matrix updates are unchanged.
  - If every way is locked, victim_valid = 0 and victim_way holds its previous value.
  - If all unlocked ways are valid, the victim is the unlocked way with the fewest 1s in its row, lowest index on tie.
- Undefined: no lock_mask port; behaviour exactly as above.

Test Plan:
- Reset then idle, WAYS=4:
  - victim_way = 0, all_valid = 0, victim_valid 0 -> 1 after first edge.
- Fills to ways 0,1,2,3 on consecutive cycles:
  - victim_way sequence 1,2,3,0.
  - all_valid = 1 from the cycle after the way 3 fill.
- All valid, then hits 0,2,1 (access_fill = 0):
  - victim_way = 3.
  - Then hit 3 -> victim_way = 0.
- All valid, invalidate way 2 while accessing way 0 in the same cycle:
  - Next cycle victim_way = 2, all_valid = 0, way 0 is MRU.
  - Same-way case: access and invalidate way 1 together -> valid[1] unchanged, way 1 MRU.
- Reset asserted mid-sequence, asynchronously between edges:
  - Outputs return to reset values immediately.
  - Subsequent fills reproduce the 1,2,3,0 sequence.
- LRU_WAY_LOCK_EN, all valid, LRU = 0, lock_mask = 4'b0001:
  - victim_way = the next-oldest way.
  - lock_mask = 4'b1111 -> victim_valid = 0.
